// File: rtl/game_mode_seq_if.sv
// Bundle of the game-mode sequencer's control inputs and status outputs.
// master drives the player/menu controls; slave is the sequencer itself.
interface game_mode_seq_if #(
  parameter int NUM_PLAYERS  = 2,
  parameter int LIFE_W       = 2,
  parameter int SCORE_DIGITS = 2
);
  logic                          p_tick;
  logic                          sel_single;
  logic                          sel_multi;
  logic [NUM_PLAYERS-1:0]        miss;
  logic                          hit;
  logic                          restart;
  logic                          cont_yes;
  logic                          cont_no;
  logic                          pause_btn;
  logic [2:0]                    state;
  logic [NUM_PLAYERS*LIFE_W-1:0] lives;
  logic [4*SCORE_DIGITS-1:0]     score;
  logic [1:0]                    winner;
  logic                          winner_valid;
  logic                          new_game;

  modport master (
    output p_tick, sel_single, sel_multi, miss, hit, restart, cont_yes, cont_no, pause_btn,
    input  state, lives, score, winner, winner_valid, new_game
  );

  modport slave (
    input  p_tick, sel_single, sel_multi, miss, hit, restart, cont_yes, cont_no, pause_btn,
    output state, lives, score, winner, winner_valid, new_game
  );
endinterface

// File: rtl/game_mode_seq.sv
// Game mode sequencer: menu / single / multi / game-over / continue screens,
// per-player life counters and a BCD score for single-player mode.
// Mode changes happen only on p_tick; lives and score act on every clk.
// Optional feature: define GAME_PAUSE_EN to enable the PAUSE mode.
module game_mode_seq #(
  parameter int NUM_PLAYERS  = 2,
  parameter int LIFE_W       = 2,
  parameter int LIVES_INIT   = 3,
  parameter int SCORE_DIGITS = 2
) (
  input logic            clk,
  input logic            reset,
  game_mode_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_MENU   = 3'd0,
    ST_SINGLE = 3'd1,
    ST_OVER   = 3'd2,
    ST_MULTI  = 3'd3,
    ST_CONT   = 3'd4,
    ST_PAUSE  = 3'd5
  } state_t;

  state_t                    state_reg, state_next;
  logic                      reload;        // combinational: transition reloads lives/score
  logic                      reload_go;     // reload actually taken this edge
  logic                      new_game_reg;
  logic [LIFE_W-1:0]         lives_reg [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]    life_zero;
  logic [4*SCORE_DIGITS-1:0] score_reg, score_inc;
  logic [1:0]                winner_idx;
  logic                      winner_found;

`ifdef GAME_PAUSE_EN
  state_t pause_origin_reg;
  logic   pause_pend_reg;
  logic   pause_req;

  // A pause pulse may arrive between ticks; it is held until the next p_tick.
  assign pause_req = bus.pause_btn | pause_pend_reg;
`endif

  assign reload_go = bus.p_tick & reload;

  // Next-mode decision; reload flags the entries that start a fresh game.
  always_comb begin
    state_next = state_reg;
    reload     = 1'b0;
    case (state_reg)
      ST_MENU: begin
        if (bus.sel_single) begin
          state_next = ST_SINGLE;
          reload     = 1'b1;
        end else if (bus.sel_multi && (NUM_PLAYERS > 1)) begin
          state_next = ST_MULTI;
          reload     = 1'b1;
        end
      end
      ST_SINGLE: begin
        if (life_zero[0]) state_next = ST_OVER;
`ifdef GAME_PAUSE_EN
        else if (pause_req) state_next = ST_PAUSE;
`endif
      end
      ST_OVER: begin
        if (bus.restart) state_next = ST_MENU;
      end
      ST_MULTI: begin
        if (|life_zero) state_next = ST_CONT;
`ifdef GAME_PAUSE_EN
        else if (pause_req) state_next = ST_PAUSE;
`endif
      end
      ST_CONT: begin
        if (bus.cont_yes) begin
          state_next = ST_MULTI;
          reload     = 1'b1;
        end else if (bus.cont_no) begin
          state_next = ST_MENU;
        end
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSE: begin
        if (pause_req) state_next = pause_origin_reg;
      end
`endif
      default: state_next = ST_MENU;
    endcase
  end

  // Mode register advances only on pixel ticks; reset wins regardless of p_tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_MENU;
      new_game_reg <= 1'b0;
    end else begin
      if (bus.p_tick) state_reg <= state_next;
      new_game_reg <= reload_go;
    end
  end

`ifdef GAME_PAUSE_EN
  // Remember where the pause came from, and latch pause requests between ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pause_origin_reg <= ST_SINGLE;
      pause_pend_reg   <= 1'b0;
    end else begin
      if (bus.p_tick && (state_next == ST_PAUSE) && (state_reg != ST_PAUSE))
        pause_origin_reg <= state_reg;
      pause_pend_reg <= !bus.p_tick && pause_req &&
                        ((state_reg == ST_SINGLE) || (state_reg == ST_MULTI) ||
                         (state_reg == ST_PAUSE));
    end
  end
`endif

  // One saturating life counter per player; only player 0 counts in single mode.
  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_life
      logic dec_en;
      assign dec_en = bus.miss[gi] &&
                      ((state_reg == ST_MULTI) || ((state_reg == ST_SINGLE) && (gi == 0)));
      assign life_zero[gi] = (lives_reg[gi] == '0);
      assign bus.lives[gi*LIFE_W +: LIFE_W] = lives_reg[gi];

      // Reload on a fresh game, otherwise count misses down to zero.
      always_ff @(posedge clk) begin
        if (!reset)                      lives_reg[gi] <= LIFE_W'(LIVES_INIT);
        else if (reload_go)              lives_reg[gi] <= LIFE_W'(LIVES_INIT);
        else if (dec_en && !life_zero[gi]) lives_reg[gi] <= lives_reg[gi] - 1'b1;
      end
    end
  endgenerate

  // BCD increment: ripple a carry through the digits, 9 rolls over to 0.
  always_comb begin
    logic carry;
    score_inc = score_reg;
    carry     = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (carry) begin
        if (score_reg[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = score_reg[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Score clears on a fresh game and counts paddle hits only in single mode.
  always_ff @(posedge clk) begin
    if (!reset)                                   score_reg <= '0;
    else if (reload_go)                           score_reg <= '0;
    else if (bus.hit && (state_reg == ST_SINGLE)) score_reg <= score_inc;
  end

  // Winner is the lowest-numbered player still holding a life.
  always_comb begin
    winner_idx   = 2'd0;
    winner_found = 1'b0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (!life_zero[i]) begin
        winner_idx   = 2'(i);
        winner_found = 1'b1;
      end
    end
  end

  assign bus.state        = state_reg;
  assign bus.score        = score_reg;
  assign bus.new_game     = new_game_reg;
  assign bus.winner       = (state_reg == ST_CONT) ? winner_idx : 2'd0;
  assign bus.winner_valid = (state_reg == ST_CONT) && winner_found;

endmodule

// File: tb/tb_game_mode_seq.sv
// Scoreboard bench for game_mode_seq (2 players, 2-bit lives, 2 BCD digits).
// Stimulus queues every expected output snapshot; the monitor pops one each
// time the DUT's observable outputs change and compares.
module tb_game_mode_seq;

  typedef logic [18:0] snap_t;  // {state, lives[1], lives[0], score, winner, wv, new_game}
  typedef struct {
    snap_t v;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  game_mode_seq_if #(.NUM_PLAYERS(2), .LIFE_W(2), .SCORE_DIGITS(2)) bus ();

  game_mode_seq #(.NUM_PLAYERS(2), .LIFE_W(2), .LIVES_INIT(3), .SCORE_DIGITS(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(int st, int l1, int l0, int sc, int w, int wv, int ng);
    return {st[2:0], l1[1:0], l0[1:0], sc[7:0], w[1:0], wv[0], ng[0]};
  endfunction

  function automatic int bcd(int n);
    int m;
    m = n % 100;
    return ((m / 10) << 4) | (m % 10);
  endfunction

  task automatic expect_chg(string nm, snap_t v);
    exp_t e;
    e.v  = v;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then drop every pulse/level control.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.sel_single = 1'b0;
    bus.sel_multi  = 1'b0;
    bus.miss       = 2'b00;
    bus.hit        = 1'b0;
    bus.restart    = 1'b0;
    bus.cont_yes   = 1'b0;
    bus.cont_no    = 1'b0;
    bus.pause_btn  = 1'b0;
  endtask

  // Monitor: every change on the outputs must match the next queued expectation.
  initial begin
    snap_t prev, cur;
    exp_t  e;
    prev = 'x;
    forever begin
      @(negedge clk);
      cur = {bus.state, bus.lives, bus.score, bus.winner, bus.winner_valid, bus.new_game};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change got st=%0d lives=%h score=%h win=%0d wv=%0b ng=%0b, required no change",
                   cur[18:16], cur[15:12], cur[11:4], cur[3:2], cur[1], cur[0]);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.v) begin
            errors++;
            $display("FAIL %s got st=%0d lives=%h score=%h win=%0d wv=%0b ng=%0b, required st=%0d lives=%h score=%h win=%0d wv=%0b ng=%0b",
                     e.nm, cur[18:16], cur[15:12], cur[11:4], cur[3:2], cur[1], cur[0],
                     e.v[18:16], e.v[15:12], e.v[11:4], e.v[3:2], e.v[1], e.v[0]);
          end else begin
            $display("check %s ok st=%0d lives=%h score=%h win=%0d wv=%0b ng=%0b",
                     e.nm, cur[18:16], cur[15:12], cur[11:4], cur[3:2], cur[1], cur[0]);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    reset          = 1'b0;
    bus.p_tick     = 1'b1;
    bus.sel_single = 1'b0;
    bus.sel_multi  = 1'b0;
    bus.miss       = 2'b00;
    bus.hit        = 1'b0;
    bus.restart    = 1'b0;
    bus.cont_yes   = 1'b0;
    bus.cont_no    = 1'b0;
    bus.pause_btn  = 1'b0;

    // Reset state
    expect_chg("reset_state", mk(0, 3, 3, 0, 0, 0, 0));
    tick();
    tick();
    reset = 1'b1;

    // Mode must not change without p_tick
    bus.p_tick = 1'b0;
    bus.sel_single = 1'b1; tick();
    bus.sel_single = 1'b1; tick();
    bus.p_tick = 1'b1;

    // Single game: three misses to game over, then restart
    bus.sel_single = 1'b1;
    expect_chg("single_entry", mk(1, 3, 3, 0, 0, 0, 1)); tick();
    expect_chg("new_game_drop", mk(1, 3, 3, 0, 0, 0, 0)); tick();
    for (int k = 2; k >= 0; k--) begin
      bus.miss = 2'b01;
      expect_chg("single_miss", mk(1, 3, k, 0, 0, 0, 0)); tick();
    end
    expect_chg("single_over", mk(2, 3, 0, 0, 0, 0, 0)); tick();
    bus.restart = 1'b1;
    expect_chg("restart_menu", mk(0, 3, 0, 0, 0, 0, 0)); tick();
    bus.hit = 1'b1; tick();  // ignored in MENU

    // Score: BCD count through 99 and wrap
    bus.sel_single = 1'b1;
    expect_chg("single_reload", mk(1, 3, 3, 0, 0, 0, 1)); tick();
    expect_chg("new_game_drop", mk(1, 3, 3, 0, 0, 0, 0)); tick();
    for (int n = 1; n <= 103; n++) begin
      bus.hit = 1'b1;
      expect_chg((n == 99) ? "score_99" : (n == 100) ? "score_wrap" : "score_hit",
                 mk(1, 3, 3, bcd(n), 0, 0, 0));
      tick();
    end
    bus.miss = 2'b10; tick();  // player 1 ignored in single mode
    for (int k = 2; k >= 0; k--) begin
      bus.miss = 2'b01;
      expect_chg("single_miss_score", mk(1, 3, k, 3, 0, 0, 0)); tick();
    end
    expect_chg("over_score_held", mk(2, 3, 0, 3, 0, 0, 0)); tick();
    bus.hit = 1'b1; tick();  // ignored in OVER
    bus.restart = 1'b1;
    expect_chg("menu_score_held", mk(0, 3, 0, 3, 0, 0, 0)); tick();

    // Multi: simultaneous misses, nobody left
    bus.sel_multi = 1'b1;
    expect_chg("multi_entry", mk(3, 3, 3, 0, 0, 0, 1)); tick();
    expect_chg("new_game_drop", mk(3, 3, 3, 0, 0, 0, 0)); tick();
    for (int k = 2; k >= 0; k--) begin
      bus.miss = 2'b11;
      expect_chg("multi_dual_miss", mk(3, k, k, 0, 0, 0, 0)); tick();
    end
    expect_chg("cont_no_winner", mk(4, 0, 0, 0, 0, 0, 0)); tick();
    bus.cont_yes = 1'b1;
    bus.cont_no  = 1'b1;
    expect_chg("cont_yes_reload", mk(3, 3, 3, 0, 0, 0, 1)); tick();
    expect_chg("new_game_drop", mk(3, 3, 3, 0, 0, 0, 0)); tick();

    // Player 1 out -> player 0 wins
    for (int k = 2; k >= 0; k--) begin
      bus.miss = 2'b10;
      expect_chg("multi_miss_p1", mk(3, k, 3, 0, 0, 0, 0)); tick();
    end
    expect_chg("cont_winner0", mk(4, 0, 3, 0, 0, 1, 0)); tick();
    bus.cont_yes = 1'b1;
    expect_chg("cont_yes_reload", mk(3, 3, 3, 0, 0, 0, 1)); tick();
    expect_chg("new_game_drop", mk(3, 3, 3, 0, 0, 0, 0)); tick();

    // Player 0 out -> player 1 wins
    for (int k = 2; k >= 0; k--) begin
      bus.miss = 2'b01;
      expect_chg("multi_miss_p0", mk(3, 3, k, 0, 0, 0, 0)); tick();
    end
    expect_chg("cont_winner1", mk(4, 3, 0, 0, 1, 1, 0)); tick();
    bus.cont_no = 1'b1;
    expect_chg("cont_no_menu", mk(0, 3, 0, 0, 0, 0, 0)); tick();

    // Back into multi, pause behaviour, then reset mid-game
    bus.sel_multi = 1'b1;
    expect_chg("multi_entry", mk(3, 3, 3, 0, 0, 0, 1)); tick();
    expect_chg("new_game_drop", mk(3, 3, 3, 0, 0, 0, 0)); tick();
`ifdef GAME_PAUSE_EN
    bus.pause_btn = 1'b1;
    expect_chg("pause_enter", mk(5, 3, 3, 0, 0, 0, 0)); tick();
    bus.miss = 2'b11; tick();  // ignored while paused
    bus.miss = 2'b01; tick();
    bus.pause_btn = 1'b1;
    expect_chg("pause_exit", mk(3, 3, 3, 0, 0, 0, 0)); tick();
`else
    bus.pause_btn = 1'b1; tick();  // pause disabled: no effect
    tick();
`endif
    bus.miss = 2'b10;
    expect_chg("multi_miss_pre_reset", mk(3, 2, 3, 0, 0, 0, 0)); tick();
    reset      = 1'b0;
    bus.p_tick = 1'b0;
    bus.miss   = 2'b11;
    expect_chg("midgame_reset", mk(0, 3, 3, 0, 0, 0, 0)); tick();
    reset      = 1'b1;
    bus.p_tick = 1'b1;

    // Menu priority: single wins over multi
    bus.sel_single = 1'b1;
    bus.sel_multi  = 1'b1;
    expect_chg("single_priority", mk(1, 3, 3, 0, 0, 0, 1)); tick();
    expect_chg("new_game_drop", mk(1, 3, 3, 0, 0, 0, 0)); tick();

    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_expectations got %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_mode_seq.md
GAME_MODE_SEQ -- requirements
Module: game_mode_seq

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of player channels (legal 1..4; MULTI unreachable when 1).
REQ-002 Parameter LIFE_W, default 2, width of each per-player life counter.
REQ-003 Parameter LIVES_INIT, default 3, life reload value (1..2^LIFE_W-1).
REQ-004 Parameter SCORE_DIGITS, default 2, number of BCD digits in the single-player score.
REQ-005 clk  input  1  system clock; one clock; reset is synchronous and active-low.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 p_tick  input  1  pixel-tick enable; gates state transitions.
REQ-008 sel_single, sel_multi  input  1 each  menu selections, level.
REQ-009 miss  input  NUM_PLAYERS  per-player one-clk miss pulses.
REQ-010 hit  input  1  one-clk paddle-hit pulse (single mode).
REQ-011 restart, cont_yes, cont_no  input  1 each  game-over and continue-screen choices, level.
REQ-012 pause_btn  input  1  one-clk pause toggle pulse.
REQ-013 state  output  3  current mode: MENU=0, SINGLE=1, OVER=2, MULTI=3, CONT=4, PAUSE=5.
REQ-014 lives  output  NUM_PLAYERS*LIFE_W  packed life counts, player 0 in LSBs.
REQ-015 score  output  4*SCORE_DIGITS  packed BCD score, digit 0 in LSBs.
REQ-016 winner  output  2  winning player index; winner_valid  output  1  winner meaningful.
REQ-017 new_game  output  1  one-clk pulse on every entry into SINGLE or MULTI from MENU or CONT.

Function
REQ-018 State register SHALL update only on clk edges where p_tick=1; all next-state decisions use inputs sampled that cycle.
REQ-019 MENU: sel_single -> SINGLE (priority); else sel_multi and NUM_PLAYERS>1 -> MULTI; else hold.
REQ-020 Entering SINGLE/MULTI from MENU or CONT SHALL reload all lives to LIVES_INIT and clear score to 0, in the same cycle as the state change.
REQ-021 Life counters SHALL act on every clk (not p_tick-gated): miss[i] decrements lives[i] by 1 in SINGLE (player 0 only; other misses ignored) and MULTI (all players), saturating at 0.
REQ-022 Simultaneous misses SHALL decrement each affected counter independently in the same cycle.
REQ-023 hit in SINGLE SHALL increment score as a BCD counter with per-digit carry; all-9s + 1 wraps to all-0s; hit ignored in all other states.
REQ-024 SINGLE -> OVER when lives[0]==0; MULTI -> CONT when any lives[i]==0.
REQ-025 OVER -> MENU on restart; CONT -> MULTI on cont_yes (priority), -> MENU on cont_no; else hold.
REQ-026 In CONT, winner = lowest index with lives>0, winner_valid=1; if all lives are 0, winner=0, winner_valid=0; outside CONT both are 0.
REQ-027 lives and score SHALL hold their values in OVER, CONT and MENU until the next reload.
REQ-028 Unused state encodings SHALL return to MENU on the next p_tick.

Reset
REQ-029 reset=0 at a clk edge SHALL force state=MENU, lives=LIVES_INIT for every player, score=0, winner=0, winner_valid=0, new_game=0, regardless of p_tick.
REQ-030 Reset asserted mid-game SHALL take priority over any simultaneous miss, hit or transition.

Configuration
REQ-031 Macro GAME_PAUSE_EN defined: pause_btn in SINGLE/MULTI SHALL enter PAUSE on the next p_tick, remembering the origin state; pause_btn in PAUSE returns to the origin; miss and hit are ignored in PAUSE; lives and score held.
REQ-032 GAME_PAUSE_EN undefined: pause_btn port is present but ignored; PAUSE is unreachable.

Verification
REQ-033 Reset, sel_single, 3 miss[0] pulses -> state 0->1, lives[0] 3->2->1->0, state=2 at next p_tick; restart -> state=0.
REQ-034 SINGLE, 100 hit pulses (SCORE_DIGITS=2) -> score 0x99 after 99 hits, 0x00 after the 100th.
REQ-035 MULTI, miss=2'b11 same cycle three times -> lives both 0, state=4, winner_valid=0; cont_yes -> state=3, lives=3/3, new_game pulses once.
REQ-036 MULTI, 3 miss[1] pulses -> state=4, winner=0, winner_valid=1; cont_no -> state=0.
REQ-037 GAME_PAUSE_EN: pause_btn in MULTI -> state=5; miss pulses ignored (lives unchanged); pause_btn -> state=3.
REQ-038 reset=0 asserted in MULTI with p_tick=0 and a concurrent miss -> next cycle state=0, lives=3/3, score=0.
